// File: rtl/seq_lshift.sv
// ---------------------------------------------------------------------------
// seq_lshift
//
// Sequential logical left shifter. Moves the operand one bit position per
// clock under a start/busy/done handshake, and reports the last bit that
// left the MSB. It is the small, slow alternative to a combinational SLL
// path in the ALU result mux.
//
// Parameters
//   WIDTH    data path width in bits
//   SHAMT_W  width of the shift count; counts 0 .. 2**SHAMT_W-1 are accepted
//
// Ports
//   clk           system clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   start         request pulse, only looked at while idle
//   data_in       operand, captured when a start is accepted
//   shift_amount  left-shift count, captured when a start is accepted
//   busy          high while the unit is shifting
//   done          one-cycle pulse marking data_out / carry_out as valid
//   data_out      shifted result, held until the next accepted start
//   carry_out     last bit shifted out of the MSB (0 for a zero count)
// ---------------------------------------------------------------------------
module seq_lshift #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shift_amount,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   data_out,
  output logic               carry_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shiftReg_q, shiftReg_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  // Next-state and datapath logic. The shift register doubles as the
  // visible result, so it only changes on an accepted start or while
  // shifting; in IDLE and DONE it simply holds.
  always_comb begin
    state_d    = state_q;
    shiftReg_d = shiftReg_q;
    count_d    = count_q;
    carry_d    = carry_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shiftReg_d = data_in;
          count_d    = shift_amount;
          carry_d    = 1'b0;
          if (shift_amount == '0) begin
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        // Counts past WIDTH keep shifting zeros in rather than stopping
        // early, so latency depends only on the requested count.
        carry_d    = shiftReg_q[WIDTH-1];
        shiftReg_d = {shiftReg_q[WIDTH-2:0], 1'b0};
        count_d    = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        // done is registered, so the pulse appears in the cycle after the
        // DONE state, which is also the first cycle a new start can land.
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
  end

  // State and output registers. Reset discards any operation in flight,
  // including a pending done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shiftReg_q <= '0;
      count_q    <= '0;
      carry_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shiftReg_q <= shiftReg_d;
      count_q    <= count_d;
      carry_q    <= carry_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign data_out  = shiftReg_q;
  assign carry_out = carry_q;

endmodule

// File: tb/tb_seq_lshift.sv
// ---------------------------------------------------------------------------
// tb_seq_lshift
//
// Self-checking bench for seq_lshift. A transaction-level model predicts
// busy, done, data_out and carry_out for every cycle from the accepted
// operand, the count and the number of edges since acceptance; directed
// operations with literal results pin that model down, followed by a long
// randomized run with starts arriving at arbitrary times.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_lshift;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               start = 1'b0;
  logic [WIDTH-1:0]   data_in = '0;
  logic [SHAMT_W-1:0] shift_amount = '0;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   data_out;
  logic               carry_out;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit compareEn = 1'b0;

  bit               mHasOp = 1'b0;
  int               mAccept = 0;
  int               mN = 0;
  logic [WIDTH-1:0] mData = '0;

  logic [WIDTH-1:0] eData;
  logic             eCarry;
  logic             eBusy;
  logic             eDone;
  int               eJ;
  int               eJClamped;

  seq_lshift #(
    .WIDTH  (WIDTH),
    .SHAMT_W(SHAMT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .data_in     (data_in),
    .shift_amount(shift_amount),
    .busy        (busy),
    .done        (done),
    .data_out    (data_out),
    .carry_out   (carry_out)
  );

  always #5 clk = ~clk;

  // Value of the operand after j single-bit left shifts.
  function automatic logic [WIDTH-1:0] shiftedBy(input logic [WIDTH-1:0] d, input int j);
    if (j >= WIDTH) return '0;
    return d << j;
  endfunction

  // Bit that left the MSB on the j-th shift: original bit WIDTH-j.
  function automatic logic lastOut(input logic [WIDTH-1:0] d, input int j);
    if (j == 0 || j > WIDTH) return 1'b0;
    return d[WIDTH-j];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Edge counter; the model refers to edges by this index.
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the request side: a start is taken only when the previous
  // operation (N shifts, a DONE cycle, then the done cycle) has finished.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mHasOp <= 1'b0;
    end else if (start && (!mHasOp || (cyc + 1) >= mAccept + mN + 2)) begin
      mHasOp  <= 1'b1;
      mAccept <= cyc + 1;
      mN      <= int'(shift_amount);
      mData   <= data_in;
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (compareEn) begin
      if (!mHasOp) begin
        eData  = '0;
        eCarry = 1'b0;
        eBusy  = 1'b0;
        eDone  = 1'b0;
      end else begin
        eJ        = cyc - mAccept;
        eJClamped = (eJ > mN) ? mN : eJ;
        eData     = shiftedBy(mData, eJClamped);
        eCarry    = lastOut(mData, eJClamped);
        eBusy     = (eJ < mN);
        eDone     = (eJ == mN + 1);
      end
      checkOutput("cmp busy", busy, eBusy);
      checkOutput("cmp done", done, eDone);
      checkOutput("cmp data_out", data_out, eData);
      checkOutput("cmp carry_out", carry_out, eCarry);
    end
  end

  // Drive one start pulse. Returns just after the accept edge with busy as
  // sampled in the first cycle after it.
  task automatic applyStimulus(input logic [WIDTH-1:0] d, input int n, input bit immediate,
                               output bit busyFirst);
    if (!immediate) @(negedge clk);
    #1;
    start        = 1'b1;
    data_in      = d;
    shift_amount = SHAMT_W'(n);
    @(negedge clk);
    busyFirst = busy;
    #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done and check the literal result and latency.
  // Returns on the negedge where done was seen.
  task automatic awaitDone(input string name, input int startCyc, input int n,
                           input logic [WIDTH-1:0] expData, input logic expCarry,
                           input int busyCount, input bit checkBusy);
    bit seen = 1'b0;
    int busyCycles = busyCount;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      else if (busy) busyCycles++;
    end
    checkOutput({name, " done seen"}, seen, 1);
    if (seen) begin
      checkOutput({name, " latency"}, cyc - startCyc, n + 1);
      checkOutput({name, " data_out"}, data_out, expData);
      checkOutput({name, " carry_out"}, carry_out, expCarry);
      if (checkBusy) checkOutput({name, " busy cycles"}, busyCycles, n);
    end
  endtask

  task automatic runOp(input string name, input logic [WIDTH-1:0] d, input int n,
                       input logic [WIDTH-1:0] expData, input logic expCarry, input bit immediate);
    bit b;
    int k;
    applyStimulus(d, n, immediate, b);
    k = cyc;
    awaitDone(name, k, n, expData, expCarry, b ? 1 : 0, 1'b1);
  endtask

  task automatic countDone(input string name, input int cycles, input int expected);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    checkOutput(name, seen, expected);
  endtask

  initial begin
    bit b;
    int k;
    int n;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    compareEn = 1'b1;
    checkOutput("reset data_out", data_out, 0);
    checkOutput("reset carry_out", carry_out, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    #1 rst_n = 1'b1;

    runOp("basic", 32'h8000_0001, 1, 32'h0000_0002, 1'b1, 1'b0);
    runOp("zero", 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    runOp("n31", 32'h0000_0001, 31, 32'h8000_0000, 1'b0, 1'b0);
    runOp("n32", 32'h0000_0001, 32, 32'h0000_0000, 1'b1, 1'b0);
    runOp("n63", 32'h0000_0001, 63, 32'h0000_0000, 1'b0, 1'b0);
    runOp("b2b", 32'h0000_0003, 30, 32'hC000_0000, 1'b0, 1'b1);

    // Start while busy: the second request lands two cycles in and is dropped.
    applyStimulus(32'h0000_00F0, 4, 1'b0, b);
    k = cyc;
    @(negedge clk);
    #1;
    start        = 1'b1;
    data_in      = 32'h0000_0001;
    shift_amount = SHAMT_W'(1);
    @(negedge clk);
    #1;
    start = 1'b0;
    awaitDone("busy start", k, 4, 32'h0000_0F00, 1'b0, 0, 1'b0);
    countDone("busy start extra done", 10, 0);

    // Reset in the middle of a long shift.
    applyStimulus(32'hFFFF_FFFF, 20, 1'b0, b);
    repeat (4) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midreset data_out", data_out, 0);
    checkOutput("midreset busy", busy, 0);
    checkOutput("midreset carry_out", carry_out, 0);
    checkOutput("midreset done", done, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    countDone("midreset no done", 30, 0);

    // Randomized traffic with starts at any time, including while busy.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      start   = ($urandom_range(0, 2) == 0);
      data_in = $urandom;
      case ($urandom_range(0, 7))
        0:       n = 0;
        1:       n = WIDTH - 1;
        2:       n = WIDTH;
        3:       n = WIDTH + 1;
        4:       n = (1 << SHAMT_W) - 1;
        default: n = $urandom_range(1, 12);
      endcase
      shift_amount = SHAMT_W'(n);
      if ($urandom_range(0, 399) == 0) begin
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
      end
    end
    @(negedge clk);
    #1 start = 1'b0;
    repeat (80) @(negedge clk);

    compareEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_lshift.md
Name: seq_lshift

Overview:
- Sequential logical left-shift unit; the left-direction companion to the ALU's combinational right shifter.
- Shifts one bit position per clock under a start/busy/done handshake.
- Reports the last bit shifted out of the MSB.
- Feeds the ALU result mux for SLL operations when area matters more than latency.

Parameters:
- WIDTH, 32, data path width in bits.
- SHAMT_W, 6, width of shift_amount; amounts 0..2^SHAMT_W-1 are accepted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- data_in  input  WIDTH  operand; captured on accepted start.
- shift_amount  input  SHAMT_W  left-shift count; captured on accepted start.
- busy  output  1  high while an operation is in progress (SHIFT state).
- done  output  1  single-cycle pulse when data_out is valid.
- data_out  output  WIDTH  shifted result; held stable until next accepted start.
- carry_out  output  1  last bit shifted out of MSB; 0 if shift_amount==0.

Behaviour:
- Reset (rst_n low, async): state=IDLE; data_out=0, carry_out=0, busy=0, done=0, internal counter=0. Takes effect immediately, including mid-operation. In-flight operation discarded; no done is issued for it.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1 at edge k:
  - data_in loads into the shift register (data_out); shift_amount loads into the counter; carry_out clears to 0.
  - If shift_amount==0, next state is DONE. Otherwise next state is SHIFT and busy=1.
- SHIFT, each edge:
  - carry_out <= data_out[WIDTH-1]; data_out <= {data_out[WIDTH-2:0],1'b0}; counter decrements.
  - When counter reaches 1 (this edge applies the last shift), next state is DONE.
- DONE: done=1 for exactly one cycle, busy=0; next state is IDLE unconditionally.
- Latency: for shift amount N, done is high in the cycle following edge k+N+1. N=0 gives done after edge k+1.
- Throughput: a new start is accepted in the IDLE cycle after DONE, so back-to-back operations cost N+2 cycles each.
- start while busy or in DONE: ignored, with no effect on the operation in progress. start is not queued.
- Shift amounts ≥ WIDTH: the unit continues shifting zeros in. Result is 0.
  - carry_out = data_in[0] when N==WIDTH.
  - carry_out = 0 when N>WIDTH.
  - Latency stays N+1; the unit does not saturate early.
- Outputs are registered; no combinational path from inputs to outputs.
- Counter width is SHAMT_W; it does not wrap, because it is loaded only on accepted start.
- Logical shift only: vacated LSBs are always filled with 0. No sign handling.

Test Plan:
- Reset mid-shift: start with data_in=32'hFFFF_FFFF, N=20; assert rst_n=0 at cycle 5 -> data_out=0, busy=0, carry_out=0 immediately; no done pulse follows.
- Basic shift: data_in=32'h8000_0001, N=1 -> done after edge k+2; data_out=32'h0000_0002, carry_out=1; busy high exactly 1 cycle.
- Zero amount: data_in=32'hDEAD_BEEF, N=0 -> done after edge k+1; data_out=32'hDEAD_BEEF, carry_out=0; busy never asserted.
- Boundary amounts: data_in=32'h0000_0001, N=31 -> data_out=32'h8000_0000, carry_out=0. Same data_in, N=32 -> data_out=0, carry_out=1. Same data_in, N=63 -> data_out=0, carry_out=0, done after 64 cycles.
- Start while busy: data_in=32'h0000_00F0, N=4, with a second start pulse (data_in=32'h1, N=1) at cycle 2 -> result is 32'h0000_0F00, carry_out=0; second request ignored; exactly one done pulse.
- Back-to-back: start asserted again in the IDLE cycle right after done with data_in=32'h0000_0003, N=30 -> data_out=32'hC000_0000, carry_out=0; the previous data_out is held stable until this start is accepted.
